// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: widths, fetch states and addressing modes.
// am_decode() maps an opcode to the mode so the decoder can reuse it.
package fetch_unit_pkg;

  localparam int REG_WIDTH  = 8;
  localparam int ADDR_WIDTH = 16;

  typedef enum logic [2:0] {
    VEC_LO, VEC_HI, OPC, OP_LO, OP_HI, PTR_LO, PTR_HI, READY
  } fetch_state_e;

  // Opcode column groups (opcode bits 1:0)
  localparam logic [1:0] AM3_GRP0 = 2'b00;
  localparam logic [1:0] AM3_GRP1 = 2'b01;
  localparam logic [1:0] AM3_GRP2 = 2'b10;
  localparam logic [1:0] AM3_GRP3 = 2'b11;

  typedef enum logic [3:0] {
    AM_IMP, AM_IMM, AM_ZP, AM_ZPX, AM_ZPY,
    AM_ABS, AM_ABSX, AM_ABSY, AM_INDX, AM_INDY
  } am_e;

  // Branches decode as AM_IMM: one operand byte, addr = that byte's address.
  function automatic am_e am_decode(input logic [7:0] opc);
    logic [2:0] aaa;
    logic [2:0] bbb;
    am_e        am;
    aaa = opc[7:5];
    bbb = opc[4:2];
    am  = AM_IMP;
    case (opc[1:0])
      AM3_GRP1: begin
        case (bbb)
          3'd0:    am = AM_INDX;
          3'd1:    am = AM_ZP;
          3'd2:    if (aaa != 3'd4) am = AM_IMM;
          3'd3:    am = AM_ABS;
          3'd4:    am = AM_INDY;
          3'd5:    am = AM_ZPX;
          3'd6:    am = AM_ABSY;
          default: am = AM_ABSX;
        endcase
      end
      AM3_GRP2: begin
        case (bbb)
          3'd0:    if (aaa == 3'd5) am = AM_IMM;
          3'd1:    am = AM_ZP;
          3'd3:    am = AM_ABS;
          3'd5:    am = (aaa == 3'd4 || aaa == 3'd5) ? AM_ZPY : AM_ZPX;
          3'd7:    if (aaa == 3'd5) am = AM_ABSY; else if (aaa != 3'd4) am = AM_ABSX;
          default: am = AM_IMP;
        endcase
      end
      AM3_GRP0: begin
        case (bbb)
          3'd0:    if (aaa == 3'd1) am = AM_ABS; else if (aaa >= 3'd5) am = AM_IMM;
          3'd1:    if (aaa == 3'd1 || aaa >= 3'd4) am = AM_ZP;
          3'd3:    if (aaa != 3'd0) am = AM_ABS;
          3'd4:    am = AM_IMM;
          3'd5:    if (aaa == 3'd4 || aaa == 3'd5) am = AM_ZPX;
          3'd7:    if (aaa == 3'd5) am = AM_ABSX;
          default: am = AM_IMP;
        endcase
      end
      default: am = AM_IMP;
    endcase
    return am;
  endfunction

endpackage

// File: rtl/fetch_unit_addr_calc.sv
// Combinational effective-address and zero-page pointer address generation.
module addr_calc #(
  parameter int REG_WIDTH  = fetch_unit_pkg::REG_WIDTH,
  parameter int ADDR_WIDTH = fetch_unit_pkg::ADDR_WIDTH
) (
  input  fetch_unit_pkg::am_e    mode_i,
  input  logic [REG_WIDTH-1:0]   b_i,
  input  logic [REG_WIDTH-1:0]   lo_i,
  input  logic [REG_WIDTH-1:0]   hi_i,
  input  logic [REG_WIDTH-1:0]   x_i,
  input  logic [REG_WIDTH-1:0]   y_i,
  output logic [ADDR_WIDTH-1:0]  ea_o,
  output logic [ADDR_WIDTH-1:0]  ptr_lo_o,
  output logic [ADDR_WIDTH-1:0]  ptr_hi_o
);
  import fetch_unit_pkg::*;

  localparam int PAD = ADDR_WIDTH - REG_WIDTH;

  logic [REG_WIDTH-1:0]  zx_sum, zy_sum, ptr_base, ptr_next;
  logic [ADDR_WIDTH-1:0] wide;

  assign zx_sum   = b_i + x_i;
  assign zy_sum   = b_i + y_i;
  assign wide     = {hi_i, lo_i};
  // Pointer bytes stay in page 0, including the +1 for the high byte
  assign ptr_base = (mode_i == AM_INDX) ? zx_sum : b_i;
  assign ptr_next = ptr_base + REG_WIDTH'(1);
  assign ptr_lo_o = {{PAD{1'b0}}, ptr_base};
  assign ptr_hi_o = {{PAD{1'b0}}, ptr_next};

  always_comb begin
    ea_o = wide;
    case (mode_i)
      AM_ZP:            ea_o = {{PAD{1'b0}}, b_i};
      AM_ZPX:           ea_o = {{PAD{1'b0}}, zx_sum};
      AM_ZPY:           ea_o = {{PAD{1'b0}}, zy_sum};
      AM_ABSX:          ea_o = wide + ADDR_WIDTH'(x_i);
      AM_ABSY, AM_INDY: ea_o = wide + ADDR_WIDTH'(y_i);
      default:          ea_o = wide;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// 6502 fetch stage: owns the PC, fetches opcode/operands/pointers and
// holds opcode, operand and effective address until the decoder is done.
module fetch_unit #(
  parameter int REG_WIDTH                      = fetch_unit_pkg::REG_WIDTH,
  parameter int ADDR_WIDTH                     = fetch_unit_pkg::ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'hFFFC
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [REG_WIDTH-1:0]  mem_data,
  input  logic                  mem_valid,
  input  logic [REG_WIDTH-1:0]  x_in,
  input  logic [REG_WIDTH-1:0]  y_in,
  output logic [REG_WIDTH-1:0]  instruction,
  output logic [REG_WIDTH-1:0]  operand,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  instruction_ready,
  input  logic                  instruction_done,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  output logic [ADDR_WIDTH-1:0] pc
);
  import fetch_unit_pkg::*;

  fetch_state_e          state_q, state_d;
  am_e                   mode_q, mode_d, opc_mode;
  logic                  waiting_q, waiting_d, boot_q;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, addr_q, addr_d;
  logic [REG_WIDTH-1:0]  instr_q, instr_d, operand_q, operand_d, lo_q, lo_d;
  logic [REG_WIDTH-1:0]  calc_b;
  logic [ADDR_WIDTH-1:0] ea, ptr_lo, ptr_hi, fetch_addr;

  // In OP_LO the operand byte is still on the bus, not yet latched
  assign calc_b   = (state_q == OP_LO) ? mem_data : operand_q;
  assign opc_mode = am_decode(mem_data);

  addr_calc #(.REG_WIDTH(REG_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_addr_calc (
    .mode_i   (mode_q),
    .b_i      (calc_b),
    .lo_i     (lo_q),
    .hi_i     (mem_data),
    .x_i      (x_in),
    .y_i      (y_in),
    .ea_o     (ea),
    .ptr_lo_o (ptr_lo),
    .ptr_hi_o (ptr_hi)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= VEC_LO;
      mode_q    <= AM_IMP;
      waiting_q <= 1'b0;
      boot_q    <= 1'b1;
      pc_q      <= '0;
      addr_q    <= '0;
      instr_q   <= '0;
      operand_q <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      waiting_q <= waiting_d;
      boot_q    <= 1'b0;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      instr_q   <= instr_d;
      operand_q <= operand_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    case (state_q)
      VEC_LO:  fetch_addr = RESET_VECTOR;
      VEC_HI:  fetch_addr = RESET_VECTOR + ADDR_WIDTH'(1);
      PTR_LO:  fetch_addr = ptr_lo;
      PTR_HI:  fetch_addr = ptr_hi;
      default: fetch_addr = pc_q;
    endcase
  end

  // boot_q holds off the first read for one cycle after reset so any late
  // mem_valid from an abandoned read lands while nothing is outstanding.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    waiting_d = waiting_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    instr_d   = instr_q;
    operand_d = operand_q;
    lo_d      = lo_q;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    if (state_q != READY) begin
      if (!waiting_q && !boot_q) begin
        mem_rd    = 1'b1;
        mem_addr  = fetch_addr;
        waiting_d = 1'b1;
      end else if (waiting_q && mem_valid) begin
        waiting_d = 1'b0;
        case (state_q)
          VEC_LO: begin
            lo_d    = mem_data;
            state_d = VEC_HI;
          end
          VEC_HI: begin
            pc_d    = {mem_data, lo_q};
            state_d = OPC;
          end
          OPC: begin
            instr_d = mem_data;
            pc_d    = pc_q + ADDR_WIDTH'(1);
            mode_d  = opc_mode;
            state_d = (opc_mode == AM_IMP) ? READY : OP_LO;
          end
          OP_LO: begin
            operand_d = mem_data;
            lo_d      = mem_data;
            pc_d      = pc_q + ADDR_WIDTH'(1);
            case (mode_q)
              AM_IMM: begin
                addr_d  = pc_q;
                state_d = READY;
              end
              AM_ZP, AM_ZPX, AM_ZPY: begin
                addr_d  = ea;
                state_d = READY;
              end
              AM_INDX, AM_INDY: state_d = PTR_LO;
              default:          state_d = OP_HI;
            endcase
          end
          OP_HI: begin
            pc_d    = pc_q + ADDR_WIDTH'(1);
            addr_d  = ea;
            state_d = READY;
          end
          PTR_LO: begin
            lo_d    = mem_data;
            state_d = PTR_HI;
          end
          PTR_HI: begin
            addr_d  = ea;
            state_d = READY;
          end
          default: state_d = state_q;
        endcase
      end
    end else if (instruction_done) begin
      if (pc_load) pc_d = pc_in;
      state_d = OPC;
    end
  end

  assign instruction       = instr_q;
  assign operand           = operand_q;
  assign addr              = addr_q;
  assign pc                = pc_q;
  assign instruction_ready = (state_q == READY);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table of instructions plus hand sequences
// for reset vector, handshake/jump, PC wrap and reset during a wait-state fetch.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        mem_valid;
  logic [7:0]  x_in, y_in;
  logic [7:0]  instruction, operand;
  logic [15:0] addr, pc, pc_in;
  logic        instruction_ready, instruction_done, pc_load;

  fetch_unit dut (
    .clk               (clk),
    .reset             (reset),
    .mem_addr          (mem_addr),
    .mem_rd            (mem_rd),
    .mem_data          (mem_data),
    .mem_valid         (mem_valid),
    .x_in              (x_in),
    .y_in              (y_in),
    .instruction       (instruction),
    .operand           (operand),
    .addr              (addr),
    .instruction_ready (instruction_ready),
    .instruction_done  (instruction_done),
    .pc_load           (pc_load),
    .pc_in             (pc_in),
    .pc                (pc)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:65535];
  logic [15:0] rd_log[$];
  int          wait_cycles;
  logic        pend;
  logic [15:0] pend_addr;
  int          pend_cnt;
  int          total, bad;

  // Memory: answers each read after wait_cycles extra cycles
  always @(negedge clk) begin
    mem_valid = 1'b0;
    if (pend) begin
      if (pend_cnt == 0) begin
        mem_valid = 1'b1;
        mem_data  = mem[pend_addr];
        pend      = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    if (mem_rd === 1'b1) begin
      pend      = 1'b1;
      pend_addr = mem_addr;
      pend_cnt  = wait_cycles;
      rd_log.push_back(mem_addr);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [7:0]  b0, b1, b2;
    int          len;
    logic [7:0]  x, y;
    bit          chk_oa;
    bit          imm_addr;
    logic [15:0] exp_addr;
    bit          ptr;
    logic [15:0] p0a;
    logic [7:0]  p0d;
    logic [15:0] p1a;
    logic [7:0]  p1d;
    int          cycles;
  } vec_t;

  function automatic vec_t mk(string n, logic [7:0] b0, logic [7:0] b1, logic [7:0] b2,
                              int len, logic [7:0] x, logic [7:0] y, bit chk_oa, bit imm,
                              logic [15:0] ea, bit ptr, logic [15:0] p0a, logic [7:0] p0d,
                              logic [15:0] p1a, logic [7:0] p1d, int cyc);
    vec_t v;
    v.name = n; v.b0 = b0; v.b1 = b1; v.b2 = b2; v.len = len; v.x = x; v.y = y;
    v.chk_oa = chk_oa; v.imm_addr = imm; v.exp_addr = ea; v.ptr = ptr;
    v.p0a = p0a; v.p0d = p0d; v.p1a = p1a; v.p1d = p1d; v.cycles = cyc;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] logat(int i);
    return (i < rd_log.size()) ? 64'(rd_log[i]) : 64'hDEAD_DEAD;
  endfunction

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (instruction_ready !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    if (instruction_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got 0 want 1");
    end
  endtask

  task automatic done_pulse(input logic ld, input logic [15:0] target);
    pc_load          = ld;
    pc_in            = target;
    instruction_done = 1'b1;
    tick();
    instruction_done = 1'b0;
    pc_load          = 1'b0;
  endtask

  vec_t        tbl [13];
  vec_t        v;
  logic [15:0] cur_pc, exp_pc, exp_ea;
  int          start, cyc, n;
  logic [63:0] snap;

  initial begin
    total = 0; bad = 0;
    pend = 1'b0; mem_valid = 1'b0; mem_data = 8'h00; wait_cycles = 0;
    reset = 1'b1; instruction_done = 1'b0; pc_load = 1'b0; pc_in = 16'h0000;
    x_in = 8'h00; y_in = 8'h00;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;

    tbl[0]  = mk("zpx_wrap",   8'hB5, 8'hF0, 8'h00, 2, 8'h20, 8'h00, 1, 0, 16'h0010, 0, 16'h0, 8'h0, 16'h0, 8'h0, 4);
    tbl[1]  = mk("absx_wrap",  8'h7D, 8'hFF, 8'hFF, 3, 8'h02, 8'h00, 1, 0, 16'h0001, 0, 16'h0, 8'h0, 16'h0, 8'h0, 6);
    tbl[2]  = mk("indx_ptr",   8'hA1, 8'hFF, 8'h00, 2, 8'h00, 8'h00, 1, 0, 16'h1234, 1, 16'h00FF, 8'h34, 16'h0000, 8'h12, 8);
    tbl[3]  = mk("indy",       8'hB1, 8'h10, 8'h00, 2, 8'h00, 8'hF0, 1, 0, 16'h3110, 1, 16'h0010, 8'h20, 16'h0011, 8'h30, 8);
    tbl[4]  = mk("implied",    8'hEA, 8'h00, 8'h00, 1, 8'h00, 8'h00, 0, 0, 16'h0000, 0, 16'h0, 8'h0, 16'h0, 8'h0, 2);
    tbl[5]  = mk("abs",        8'hAD, 8'h34, 8'h12, 3, 8'h00, 8'h00, 1, 0, 16'h1234, 0, 16'h0, 8'h0, 16'h0, 8'h0, 6);
    tbl[6]  = mk("zpy_wrap",   8'hB6, 8'h80, 8'h00, 2, 8'h05, 8'h90, 1, 0, 16'h0010, 0, 16'h0, 8'h0, 16'h0, 8'h0, 4);
    tbl[7]  = mk("absy",       8'hBE, 8'h00, 8'hFF, 3, 8'h01, 8'h02, 1, 0, 16'hFF02, 0, 16'h0, 8'h0, 16'h0, 8'h0, 6);
    tbl[8]  = mk("zp",         8'h85, 8'h44, 8'h00, 2, 8'h00, 8'h00, 1, 0, 16'h0044, 0, 16'h0, 8'h0, 16'h0, 8'h0, 4);
    tbl[9]  = mk("indy_wrap",  8'h91, 8'hFF, 8'h00, 2, 8'h00, 8'h01, 1, 0, 16'h0000, 1, 16'h00FF, 8'hFF, 16'h0000, 8'hFF, 8);
    tbl[10] = mk("branch",     8'hD0, 8'h05, 8'h00, 2, 8'h00, 8'h00, 1, 1, 16'h0000, 0, 16'h0, 8'h0, 16'h0, 8'h0, 4);
    tbl[11] = mk("illegal",    8'h02, 8'h00, 8'h00, 1, 8'h00, 8'h00, 0, 0, 16'h0000, 0, 16'h0, 8'h0, 16'h0, 8'h0, 2);
    tbl[12] = mk("indx_zwrap", 8'h81, 8'hF0, 8'h00, 2, 8'h10, 8'h00, 1, 0, 16'h5678, 1, 16'h0000, 8'h78, 16'h0001, 8'h56, 8);

    // Reset state and reset vector fetch
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
    mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h42;
    tick(); tick(); tick();
    chk("rst_mem_rd", mem_rd, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_instruction", instruction, 8'h00);
    chk("rst_operand", operand, 8'h00);
    chk("rst_addr", addr, 16'h0000);
    chk("rst_ready", instruction_ready, 1'b0);
    chk("rst_pc", pc, 16'h0000);
    reset = 1'b0;
    wait_ready(cyc);
    chk("vec_rd_lo", logat(0), 16'hFFFC);
    chk("vec_rd_hi", logat(1), 16'hFFFD);
    chk("first_opc_rd", logat(2), 16'h8000);
    chk("imm_instruction", instruction, 8'hA9);
    chk("imm_operand", operand, 8'h42);
    chk("imm_addr", addr, 16'h8001);
    chk("imm_pc", pc, 16'h8002);

    // Hold without done: outputs stable, pc_load ignored
    snap = {instruction_ready, instruction, operand, addr, pc};
    pc_load = 1'b1; pc_in = 16'h1111;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("hold_stable", {instruction_ready, instruction, operand, addr, pc}, snap);
    end
    pc_load = 1'b0;

    // Table of instructions, executed back to back from 8002
    cur_pc = 16'h8002;
    for (int i = 0; i < 13; i++) begin
      v = tbl[i];
      mem[cur_pc] = v.b0;
      if (v.len > 1) mem[cur_pc + 16'd1] = v.b1;
      if (v.len > 2) mem[cur_pc + 16'd2] = v.b2;
      if (v.ptr) begin
        mem[v.p0a] = v.p0d;
        mem[v.p1a] = v.p1d;
      end
      x_in = v.x; y_in = v.y;
      start = rd_log.size();
      done_pulse(1'b0, 16'h0000);
      wait_ready(cyc);
      exp_pc = cur_pc + 16'(v.len);
      exp_ea = v.imm_addr ? cur_pc + 16'd1 : v.exp_addr;
      chk({v.name, "_cycles"}, cyc, v.cycles);
      chk({v.name, "_opc_rd"}, logat(start), cur_pc);
      chk({v.name, "_instruction"}, instruction, v.b0);
      chk({v.name, "_pc"}, pc, exp_pc);
      if (v.chk_oa) begin
        chk({v.name, "_operand"}, operand, v.b1);
        chk({v.name, "_addr"}, addr, exp_ea);
      end
      if (v.ptr) begin
        chk({v.name, "_ptr_rd_lo"}, logat(start + 2), v.p0a);
        chk({v.name, "_ptr_rd_hi"}, logat(start + 3), v.p1a);
      end
      cur_pc = exp_pc;
    end

    // Jump via pc_load on done; pc_load during OP_LO has no effect
    mem[16'hC000] = 8'hA9; mem[16'hC001] = 8'h55;
    start = rd_log.size();
    done_pulse(1'b1, 16'hC000);
    tick(); tick();
    pc_load = 1'b1; pc_in = 16'h1111;
    tick();
    pc_load = 1'b0;
    wait_ready(cyc);
    chk("jump_opc_rd", logat(start), 16'hC000);
    chk("jump_operand", operand, 8'h55);
    chk("jump_addr", addr, 16'hC001);
    chk("jump_pc_oplo_load_ignored", pc, 16'hC002);

    // PC wraps FFFF -> 0000
    mem[16'hFFFF] = 8'hA9; mem[16'h0000] = 8'h77;
    done_pulse(1'b1, 16'hFFFF);
    wait_ready(cyc);
    chk("wrap_operand", operand, 8'h77);
    chk("wrap_addr", addr, 16'h0000);
    chk("wrap_pc", pc, 16'h0001);

    // Reset during OP_HI with 3 wait cycles; stale mem_valid must be ignored
    mem[16'h0001] = 8'hAD; mem[16'h0002] = 8'hCD; mem[16'h0003] = 8'hAB;
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h90; mem[16'h9000] = 8'hEA;
    wait_cycles = 3;
    done_pulse(1'b0, 16'h0000);
    n = 0;
    while (!(mem_rd === 1'b1 && mem_addr == 16'h0003) && n < 100) begin
      tick();
      n++;
    end
    chk("midrst_ophi_seen", n < 100, 1'b1);
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("midrst_mem_rd", mem_rd, 1'b0);
    chk("midrst_mem_addr", mem_addr, 16'h0000);
    chk("midrst_instruction", instruction, 8'h00);
    chk("midrst_operand", operand, 8'h00);
    chk("midrst_addr", addr, 16'h0000);
    chk("midrst_ready", instruction_ready, 1'b0);
    chk("midrst_pc", pc, 16'h0000);
    tick();
    reset = 1'b0;
    start = rd_log.size();
    chk("midrst_idle_rd", mem_rd, 1'b0);
    wait_ready(cyc);
    chk("midrst_vec_rd", logat(start), 16'hFFFC);
    chk("midrst_vec_hi_rd", logat(start + 1), 16'hFFFD);
    chk("midrst_instruction_after", instruction, 8'hEA);
    chk("midrst_pc_after", pc, 16'h9001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
